// File: rtl/cmp_pipe.sv
// cmp_pipe: two-stage valid/ready SIMD compare unit producing per-lane masks and a zero flag.
// Define CMP_PIPE_PERF_EN to add the perf_ops / perf_true output-transfer counters.
module cmp_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned LANES = 1,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_flag,
  output logic [TAG_W-1:0] out_tag
`ifdef CMP_PIPE_PERF_EN
  ,
  output logic [31:0]      perf_ops,
  output logic [31:0]      perf_true
`endif
);

  localparam int unsigned LW = WIDTH / LANES;

  localparam logic [2:0] ModeSeq  = 3'b000;
  localparam logic [2:0] ModeSne  = 3'b001;
  localparam logic [2:0] ModeSlt  = 3'b010;
  localparam logic [2:0] ModeSle  = 3'b011;
  localparam logic [2:0] ModeSgt  = 3'b100;
  localparam logic [2:0] ModeSge  = 3'b101;
  localparam logic [2:0] ModeSltu = 3'b110;
  localparam logic [2:0] ModeSleu = 3'b111;

  if (!(LANES == 1 || LANES == 2 || LANES == 4) || (WIDTH % LANES) != 0) begin : g_bad_cfg
    $error("cmp_pipe: illegal WIDTH/LANES combination");
  end

  function automatic logic lane_true(input logic [2:0] mode, input logic eq, input logic slt,
                                     input logic ult);
    logic res;
    res = 1'b0;
    unique case (mode)
      ModeSeq:  res = eq;
      ModeSne:  res = !eq;
      ModeSlt:  res = slt;
      ModeSle:  res = slt || eq;
      ModeSgt:  res = !(slt || eq);
      ModeSge:  res = !slt;
      ModeSltu: res = ult;
      ModeSleu: res = ult || eq;
      default:  res = 1'b0;
    endcase
    return res;
  endfunction

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;
  logic [2:0]       r_s1_mode;
  logic [TAG_W-1:0] r_s1_tag;

  logic             r_s2_valid;
  logic [WIDTH-1:0] r_s2_result;
  logic             r_s2_flag;
  logic [TAG_W-1:0] r_s2_tag;

  logic             w_s2_load;
  logic [WIDTH-1:0] w_result;

  // S2 frees up when empty or draining; S1 moves under the same condition.
  assign w_s2_load = !r_s2_valid || out_ready;
  assign in_ready  = !r_s1_valid || w_s2_load;

  // Each lane compares its own sub-word; sign is the lane MSB, nothing crosses lanes.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [LW-1:0] w_a;
    logic [LW-1:0] w_b;
    logic          w_true;
    assign w_a    = r_s1_a[g*LW +: LW];
    assign w_b    = r_s1_b[g*LW +: LW];
    assign w_true = lane_true(r_s1_mode, w_a == w_b, $signed(w_a) < $signed(w_b), w_a < w_b);
    assign w_result[g*LW +: LW] = {LW{w_true}};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_a      <= '0;
      r_s1_b      <= '0;
      r_s1_mode   <= '0;
      r_s1_tag    <= '0;
      r_s2_valid  <= 1'b0;
      r_s2_result <= '0;
      r_s2_flag   <= 1'b1;
      r_s2_tag    <= '0;
    end else begin
      if (in_ready) begin
        r_s1_valid <= in_valid;
        if (in_valid) begin
          r_s1_a    <= in_a;
          r_s1_b    <= in_b;
          r_s1_mode <= in_mode;
          r_s1_tag  <= in_tag;
        end
      end
      if (w_s2_load) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2_result <= w_result;
          r_s2_flag   <= ~|w_result;
          r_s2_tag    <= r_s1_tag;
        end
      end
    end
  end

  assign out_valid  = r_s2_valid;
  assign out_result = r_s2_result;
  assign out_flag   = r_s2_flag;
  assign out_tag    = r_s2_tag;

`ifdef CMP_PIPE_PERF_EN
  logic [31:0] r_perf_ops;
  logic [31:0] r_perf_true;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_ops  <= '0;
      r_perf_true <= '0;
    end else if (r_s2_valid && out_ready) begin
      r_perf_ops <= r_perf_ops + 32'd1;
      if (!r_s2_flag) begin
        r_perf_true <= r_perf_true + 32'd1;
      end
    end
  end

  assign perf_ops  = r_perf_ops;
  assign perf_true = r_perf_true;
`endif

endmodule

// File: tb/tb_cmp_pipe.sv
// Bench for cmp_pipe: LANES=1 and LANES=4 instances share stimulus and are checked against
// an arithmetic per-lane compare model plus an in-flight queue of expected results.
module tb_cmp_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [2:0]  in_mode;
  logic [3:0]  in_tag;
  logic        out_ready;

  logic        ir1, ov1, fl1, ir4, ov4, fl4;
  logic [31:0] res1, res4;
  logic [3:0]  tg1, tg4;
`ifdef CMP_PIPE_PERF_EN
  logic [31:0] pops1, ptrue1, pops4, ptrue4;
`endif

  always #5 clk = ~clk;

  cmp_pipe #(.WIDTH(32), .LANES(1), .TAG_W(4)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1), .in_a(in_a), .in_b(in_b),
    .in_mode(in_mode), .in_tag(in_tag), .out_valid(ov1), .out_ready(out_ready),
    .out_result(res1), .out_flag(fl1), .out_tag(tg1)
`ifdef CMP_PIPE_PERF_EN
    , .perf_ops(pops1), .perf_true(ptrue1)
`endif
  );

  cmp_pipe #(.WIDTH(32), .LANES(4), .TAG_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir4), .in_a(in_a), .in_b(in_b),
    .in_mode(in_mode), .in_tag(in_tag), .out_valid(ov4), .out_ready(out_ready),
    .out_result(res4), .out_flag(fl4), .out_tag(tg4)
`ifdef CMP_PIPE_PERF_EN
    , .perf_ops(pops4), .perf_true(ptrue4)
`endif
  );

  typedef struct {
    logic [31:0] r1;
    logic [31:0] r4;
    logic [3:0]  tag;
    int          age;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   m_ops = 0, m_true1 = 0, m_true4 = 0;
  bit   post_rst = 1'b0;
  logic [3:0] tg = 4'd0;

  // Reference: split into lanes, compare with plain integer arithmetic.
  function automatic logic [31:0] ref_cmp(input int lanes, input logic [2:0] mode,
                                          input logic [31:0] a, input logic [31:0] b);
    int          lw;
    logic [31:0] r;
    longint      mask, ua, ub, sa, sb;
    bit          t;
    lw = 32 / lanes;
    r  = 32'd0;
    mask = (64'sd1 <<< lw) - 1;
    for (int i = 0; i < lanes; i++) begin
      ua = longint'({32'd0, a >> (i * lw)}) & mask;
      ub = longint'({32'd0, b >> (i * lw)}) & mask;
      sa = (ua >= (64'sd1 <<< (lw - 1))) ? ua - (64'sd1 <<< lw) : ua;
      sb = (ub >= (64'sd1 <<< (lw - 1))) ? ub - (64'sd1 <<< lw) : ub;
      case (mode)
        3'd0: t = (ua == ub);
        3'd1: t = (ua != ub);
        3'd2: t = (sa < sb);
        3'd3: t = (sa <= sb);
        3'd4: t = (sa > sb);
        3'd5: t = (sa >= sb);
        3'd6: t = (ua < ub);
        default: t = (ua <= ub);
      endcase
      if (t) r = r | 32'(mask << (i * lw));
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // One clock: drive at negedge, check, then advance the model on the rising edge.
  task automatic do_cycle(input bit r, input bit v, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] m, input bit ordy);
    bit   exp_ov, exp_ir, oxfer, ixfer;
    exp_t e;
    @(negedge clk);
    rst = r; in_valid = v; in_a = a; in_b = b; in_mode = m; in_tag = tg; out_ready = ordy;
    #1;
    exp_ov = (q.size() > 0) && (q[0].age >= 1);
    exp_ir = (q.size() < 2) || ordy;
    chk("in_ready1", 32'(ir1), 32'(exp_ir));
    chk("in_ready4", 32'(ir4), 32'(exp_ir));
    chk("out_valid1", 32'(ov1), 32'(exp_ov));
    chk("out_valid4", 32'(ov4), 32'(exp_ov));
    if (exp_ov) begin
      chk("result1", res1, q[0].r1);
      chk("flag1", 32'(fl1), 32'(q[0].r1 == 32'd0));
      chk("tag1", 32'(tg1), 32'(q[0].tag));
      chk("result4", res4, q[0].r4);
      chk("flag4", 32'(fl4), 32'(q[0].r4 == 32'd0));
      chk("tag4", 32'(tg4), 32'(q[0].tag));
    end
    if (post_rst) begin
      chk("rst_result1", res1, 32'd0);
      chk("rst_flag1", 32'(fl1), 32'd1);
      chk("rst_tag1", 32'(tg1), 32'd0);
      chk("rst_result4", res4, 32'd0);
      chk("rst_flag4", 32'(fl4), 32'd1);
      chk("rst_tag4", 32'(tg4), 32'd0);
    end
`ifdef CMP_PIPE_PERF_EN
    chk("perf_ops1", pops1, 32'(m_ops));
    chk("perf_true1", ptrue1, 32'(m_true1));
    chk("perf_ops4", pops4, 32'(m_ops));
    chk("perf_true4", ptrue4, 32'(m_true4));
`endif
    oxfer = exp_ov && ordy;
    ixfer = v && exp_ir;
    @(posedge clk);
    if (r) begin
      q.delete();
      m_ops = 0; m_true1 = 0; m_true4 = 0;
      post_rst = 1'b1;
    end else begin
      post_rst = 1'b0;
      if (oxfer) begin
        m_ops++;
        if (q[0].r1 != 32'd0) m_true1++;
        if (q[0].r4 != 32'd0) m_true4++;
        void'(q.pop_front());
      end
      foreach (q[i]) q[i].age++;
      if (ixfer) begin
        e.r1 = ref_cmp(1, m, a, b);
        e.r4 = ref_cmp(4, m, a, b);
        e.tag = tg;
        e.age = 0;
        q.push_back(e);
      end
    end
    if (v) tg = tg + 4'd1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_cycle(1'b0, 1'b0, $urandom, $urandom, 3'($urandom), 1'b1);
  endtask

  initial begin
    logic [31:0] ra, rb;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_mode = '0; in_tag = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    post_rst = 1'b1;
    idle(2);

    // Directed operands, including the sign/lane corner cases.
    tg = 4'd3;
    do_cycle(1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 3'b011, 1'b1);
    do_cycle(1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 3'b111, 1'b1);
    do_cycle(1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000, 3'b101, 1'b1);
    do_cycle(1'b0, 1'b1, 32'h8001_7F00, 32'h0001_80FF, 3'b010, 1'b1);
    do_cycle(1'b0, 1'b1, 32'h7F80_0000, 32'h80FF_0100, 3'b100, 1'b1);
    do_cycle(1'b0, 1'b1, 32'h00FF_0000, 32'h0100_0000, 3'b110, 1'b1);
    idle(3);

    // Back-to-back: 8 ops, tags 0..7, out_ready held high.
    tg = 4'd0;
    for (int i = 0; i < 8; i++) do_cycle(1'b0, 1'b1, $urandom, $urandom, 3'(i), 1'b1);
    idle(3);

    // Backpressure: feed with out_ready low for 5 cycles, then release.
    for (int i = 0; i < 5; i++) do_cycle(1'b0, 1'b1, $urandom, $urandom, 3'($urandom), 1'b0);
    for (int i = 0; i < 3; i++) do_cycle(1'b0, 1'b1, $urandom, $urandom, 3'($urandom), 1'b1);
    idle(3);

    // Random traffic with frequent equal lanes.
    for (int i = 0; i < 400; i++) begin
      ra = $urandom;
      case ($urandom % 4)
        0: rb = ra;
        1: rb = ra ^ (32'h0000_00FF << (8 * ($urandom % 4)));
        2: rb = ra ^ (32'h0000_0080 << (8 * ($urandom % 4)));
        default: rb = $urandom;
      endcase
      do_cycle(1'b0, ($urandom % 4) != 0, ra, rb, 3'($urandom), ($urandom % 3) != 0);
    end
    idle(3);

    // Reset with two ops in flight: nothing stale may appear afterwards.
    do_cycle(1'b0, 1'b1, 32'h1, 32'h2, 3'b010, 1'b0);
    do_cycle(1'b0, 1'b1, 32'h3, 32'h3, 3'b000, 1'b0);
    do_cycle(1'b0, 1'b1, 32'h5, 32'h6, 3'b110, 1'b0);
    do_cycle(1'b1, 1'b0, 32'h0, 32'h0, 3'b000, 1'b1);
    idle(5);
    do_cycle(1'b0, 1'b1, 32'h0000_0001, 32'hFFFF_FFFF, 3'b100, 1'b1);
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
